// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, store-size encodings, access-size helpers.
package mips_pkg;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_LH   = 6'h21;
    localparam logic [5:0] OP_LHU  = 6'h25;
    localparam logic [5:0] OP_LB   = 6'h20;
    localparam logic [5:0] OP_LBU  = 6'h24;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_SH   = 6'h29;
    localparam logic [5:0] OP_SB   = 6'h28;
    localparam logic [5:0] OP_HALT = 6'h3f;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Bytes touched by a load/store opcode; 0 for anything that does not access memory.
    function automatic logic [2:0] access_size(input logic [5:0] op);
        logic [2:0] s;
        case (op)
            OP_LW, OP_SW:                s = 3'd4;
            OP_LH, OP_LHU, OP_SH:        s = 3'd2;
            OP_LB, OP_LBU, OP_SB:        s = 3'd1;
            default:                     s = 3'd0;
        endcase
        return s;
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load data alignment: selects the addressed byte/half of a big-endian word and extends it.
module dm_load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  opcode,
    output logic [31:0] load_data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Byte 0 of the word sits in the top lane, so lower addresses pick higher bits.
    always_comb begin
        half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
        case (addr_lo)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Extend the selected lane according to the load flavour.
    always_comb begin
        case (opcode)
            OP_LW:   load_data = rdata;
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: drives the sized memory interface, aligns load data,
// flags bad accesses and registers the WB-bound result.
module dm_stage
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_BYTES = 1024,
    parameter int unsigned ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dm_ins_i,
    input  logic [31:0]       dm_alu_i,
    input  logic [31:0]       dm_st_data_i,
    input  logic [4:0]        dm_dst_i,
    input  logic              dm_regwen_i,
    output logic [ADDR_W-1:0] RAddr_d,
    input  logic [31:0]       Rdata_d,
    output logic              Wen,
    output logic [1:0]        WSize,
    output logic [ADDR_W-1:0] WAddr_d,
    output logic [31:0]       Wdata_d,
    output logic [31:0]       WB_ins,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_dst,
    output logic              wb_regwen,
    output logic [31:0]       fwd_dm_data,
    output logic              addr_ovf,
    output logic              misalign,
    output logic              halt_req
);

    logic [5:0]  opcode;
    logic [2:0]  size;
    logic        ld;
    logic        st;
    logic        bad;
    logic [32:0] last_byte;
    logic [31:0] load_data;
    logic [31:0] wb_data_d;

    assign opcode      = dm_ins_i[31:26];
    assign fwd_dm_data = dm_alu_i;

    dm_load_align u_load_align (
        .rdata     (Rdata_d),
        .addr_lo   (dm_alu_i[1:0]),
        .opcode    (opcode),
        .load_data (load_data)
    );

    // Decode the access and check it; the end address is formed at 33 bits so a
    // wrap past 0xFFFFFFFF still reads as out of range.
    always_comb begin
        size      = access_size(opcode);
        ld        = is_load(opcode);
        st        = is_store(opcode);
        last_byte = {1'b0, dm_alu_i} + {30'b0, size} - 33'd1;
        addr_ovf  = (ld || st) && (last_byte >= 33'(DMEM_BYTES));
        misalign  = ((size == 3'd4) && (dm_alu_i[1:0] != 2'b00)) ||
                    ((size == 3'd2) && dm_alu_i[0]);
        bad       = addr_ovf || misalign;
    end

    // Memory interface; a bad store is dropped entirely.
    always_comb begin
        RAddr_d = ld ? dm_alu_i[ADDR_W-1:0] : '0;
        Wen     = 1'b0;
        WSize   = 2'b00;
        WAddr_d = '0;
        Wdata_d = 32'h0;
        if (st && !bad) begin
            Wen     = 1'b1;
            WAddr_d = dm_alu_i[ADDR_W-1:0];
            case (size)
                3'd4: begin
                    WSize   = SZ_WORD;
                    Wdata_d = dm_st_data_i;
                end
                3'd2: begin
                    WSize   = SZ_HALF;
                    Wdata_d = {16'h0000, dm_st_data_i[15:0]};
                end
                default: begin
                    WSize   = SZ_BYTE;
                    Wdata_d = {24'h000000, dm_st_data_i[7:0]};
                end
            endcase
        end
    end

    // Write-back value: aligned load data (zero when the load was suppressed) or ALU result.
    always_comb begin
        if (ld) begin
            wb_data_d = bad ? 32'h0 : load_data;
        end else begin
            wb_data_d = dm_alu_i;
        end
    end

    // DM/WB pipeline register plus the sticky halt request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_ins    <= 32'h0;
            wb_data   <= 32'h0;
            wb_dst    <= 5'h0;
            wb_regwen <= 1'b0;
            halt_req  <= 1'b0;
        end else begin
            WB_ins    <= dm_ins_i;
            wb_data   <= wb_data_d;
            wb_dst    <= dm_dst_i;
            wb_regwen <= dm_regwen_i && !bad && !st;
            if (bad) begin
                halt_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: the driver checks combinational outputs and queues the
// expected WB-stage result; a monitor pops and checks it after each rising edge.
module tb_dm_stage;

    logic        clk;
    logic        rst;
    logic [31:0] dm_ins_i;
    logic [31:0] dm_alu_i;
    logic [31:0] dm_st_data_i;
    logic [4:0]  dm_dst_i;
    logic        dm_regwen_i;
    logic [9:0]  RAddr_d;
    logic [31:0] Rdata_d;
    logic        Wen;
    logic [1:0]  WSize;
    logic [9:0]  WAddr_d;
    logic [31:0] Wdata_d;
    logic [31:0] WB_ins;
    logic [31:0] wb_data;
    logic [4:0]  wb_dst;
    logic        wb_regwen;
    logic [31:0] fwd_dm_data;
    logic        addr_ovf;
    logic        misalign;
    logic        halt_req;

    dm_stage #(
        .DMEM_BYTES (1024),
        .ADDR_W     (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dm_ins_i     (dm_ins_i),
        .dm_alu_i     (dm_alu_i),
        .dm_st_data_i (dm_st_data_i),
        .dm_dst_i     (dm_dst_i),
        .dm_regwen_i  (dm_regwen_i),
        .RAddr_d      (RAddr_d),
        .Rdata_d      (Rdata_d),
        .Wen          (Wen),
        .WSize        (WSize),
        .WAddr_d      (WAddr_d),
        .Wdata_d      (Wdata_d),
        .WB_ins       (WB_ins),
        .wb_data      (wb_data),
        .wb_dst       (wb_dst),
        .wb_regwen    (wb_regwen),
        .fwd_dm_data  (fwd_dm_data),
        .addr_ovf     (addr_ovf),
        .misalign     (misalign),
        .halt_req     (halt_req)
    );

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] data;
        logic [4:0]  dst;
        logic        rw;
        logic        halt;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        model_halt = 1'b0;
    logic [25:0] seq = 26'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one instruction for a full cycle starting at a falling edge.
    task automatic issue(input string nm, input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] st, input logic [31:0] rdata,
                         input logic [4:0] dst, input logic rw,
                         input logic [9:0] e_raddr, input logic e_wen,
                         input logic [1:0] e_wsize, input logic [9:0] e_waddr,
                         input logic [31:0] e_wdata, input logic e_ovf, input logic e_mis,
                         input logic [31:0] e_wbdata, input logic e_wbrw);
        wb_exp_t e;
        @(negedge clk);
        dm_ins_i     = {op, seq};
        seq          = seq + 26'd1;
        dm_alu_i     = alu;
        dm_st_data_i = st;
        Rdata_d      = rdata;
        dm_dst_i     = dst;
        dm_regwen_i  = rw;
        #1;
        chk({nm, ".raddr"}, 32'(RAddr_d), 32'(e_raddr));
        chk({nm, ".wen"}, 32'(Wen), 32'(e_wen));
        chk({nm, ".wsize"}, 32'(WSize), 32'(e_wsize));
        chk({nm, ".waddr"}, 32'(WAddr_d), 32'(e_waddr));
        chk({nm, ".wdata"}, Wdata_d, e_wdata);
        chk({nm, ".ovf"}, 32'(addr_ovf), 32'(e_ovf));
        chk({nm, ".mis"}, 32'(misalign), 32'(e_mis));
        chk({nm, ".fwd"}, fwd_dm_data, alu);
        if (e_ovf || e_mis) model_halt = 1'b1;
        e.name = nm;
        e.ins  = dm_ins_i;
        e.data = e_wbdata;
        e.dst  = dst;
        e.rw   = e_wbrw;
        e.halt = model_halt;
        exp_q.push_back(e);
    endtask

    // Monitor: the WB register presents a new result after every rising edge out of reset.
    initial begin
        wb_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, ".wb_ins"}, WB_ins, e.ins);
                chk({e.name, ".wb_data"}, wb_data, e.data);
                chk({e.name, ".wb_dst"}, 32'(wb_dst), 32'(e.dst));
                chk({e.name, ".wb_regwen"}, 32'(wb_regwen), 32'(e.rw));
                chk({e.name, ".halt"}, 32'(halt_req), 32'(e.halt));
            end
        end
    end

    initial begin
        rst          = 1'b0;
        dm_ins_i     = 32'h0;
        dm_alu_i     = 32'h0;
        dm_st_data_i = 32'h0;
        dm_dst_i     = 5'h0;
        dm_regwen_i  = 1'b0;
        Rdata_d      = 32'h0;
        #2;
        chk("rst.wb_ins", WB_ins, 32'h0);
        chk("rst.wb_data", wb_data, 32'h0);
        chk("rst.wb_regwen", 32'(wb_regwen), 32'h0);
        chk("rst.halt", 32'(halt_req), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        //     name      op     alu           st            rdata         dst  rw  raddr   wen ws     waddr   wdata         ovf  mis  wbdata        wbrw
        issue("sw",     6'h2b, 32'h10,       32'hDEADBEEF, 32'h0,        5'd3, 1, 10'h0,   1, 2'b10, 10'h10,  32'hDEADBEEF, 0,   0,   32'h10,       0);
        issue("lh",     6'h21, 32'h12,       32'h0,        32'h1234F00D, 5'd4, 1, 10'h12,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'hFFFFF00D, 1);
        issue("lhu",    6'h25, 32'h12,       32'h0,        32'h1234F00D, 5'd4, 1, 10'h12,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h0000F00D, 1);
        issue("lb",     6'h20, 32'h03,       32'h0,        32'h00000080, 5'd7, 1, 10'h03,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'hFFFFFF80, 1);
        issue("lbu",    6'h24, 32'h03,       32'h0,        32'h00000080, 5'd7, 1, 10'h03,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h00000080, 1);
        issue("lb1",    6'h20, 32'h01,       32'h0,        32'h12FE5678, 5'd8, 1, 10'h01,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'hFFFFFFFE, 1);
        issue("lbu2",   6'h24, 32'h02,       32'h0,        32'h12FE5678, 5'd8, 1, 10'h02,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h00000056, 1);
        issue("lh0",    6'h21, 32'h00,       32'h0,        32'h80017FFF, 5'd9, 1, 10'h00,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'hFFFF8001, 1);
        issue("lhu2",   6'h25, 32'h02,       32'h0,        32'h80017FFF, 5'd9, 1, 10'h02,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h00007FFF, 1);
        issue("lw",     6'h23, 32'h20,       32'h0,        32'hCAFEF00D, 5'd10, 1, 10'h20, 0, 2'b00, 10'h0,   32'h0,        0,   0,   32'hCAFEF00D, 1);
        issue("lwtop",  6'h23, 32'h3FC,      32'h0,        32'h01020304, 5'd11, 1, 10'h3FC, 0, 2'b00, 10'h0,  32'h0,        0,   0,   32'h01020304, 1);
        issue("sh",     6'h29, 32'h06,       32'h1234ABCD, 32'h0,        5'd2, 1, 10'h0,   1, 2'b01, 10'h06,  32'h0000ABCD, 0,   0,   32'h06,       0);
        issue("sbtop",  6'h28, 32'h3FF,      32'h11223344, 32'h0,        5'd2, 1, 10'h0,   1, 2'b00, 10'h3FF, 32'h00000044, 0,   0,   32'h3FF,      0);
        issue("add",    6'h00, 32'h07,       32'h0,        32'h0,        5'd5, 1, 10'h0,   0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h07,       1);
        issue("lwmis",  6'h23, 32'h02,       32'h0,        32'hFFFFFFFF, 5'd6, 1, 10'h02,  0, 2'b00, 10'h0,   32'h0,        0,   1,   32'h0,        0);
        for (int i = 0; i < 5; i++) begin
            issue("nop", 6'h00, 32'h0,     32'h0,        32'h0,        5'd0, 0, 10'h0,   0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h0,        0);
        end
        issue("swbad",  6'h2b, 32'h3FE,      32'hAABBCCDD, 32'h0,        5'd1, 1, 10'h0,   0, 2'b00, 10'h0,   32'h0,        1,   1,   32'h3FE,      0);
        issue("shwrap", 6'h29, 32'hFFFFFFFE, 32'h5555AAAA, 32'h0,        5'd1, 1, 10'h0,   0, 2'b00, 10'h0,   32'h0,        1,   0,   32'hFFFFFFFE, 0);
        issue("lbovf",  6'h20, 32'h400,      32'h0,        32'h12345678, 5'd12, 1, 10'h0,  0, 2'b00, 10'h0,   32'h0,        1,   0,   32'h0,        0);
        issue("halt",   6'h3f, 32'h55,       32'h0,        32'h0,        5'd0, 0, 10'h0,   0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h55,       0);
        issue("add5",   6'h00, 32'h07,       32'h0,        32'h0,        5'd5, 1, 10'h0,   0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h07,       1);

        // Reset asserted mid-cycle, after add5 has reached WB.
        @(posedge clk);
        #3;
        rst        = 1'b0;
        model_halt = 1'b0;
        #1;
        chk("midrst.wb_ins", WB_ins, 32'h0);
        chk("midrst.wb_data", wb_data, 32'h0);
        chk("midrst.wb_dst", 32'(wb_dst), 32'h0);
        chk("midrst.wb_regwen", 32'(wb_regwen), 32'h0);
        chk("midrst.halt", 32'(halt_req), 32'h0);
        chk("midrst.fwd", fwd_dm_data, 32'h7);
        // A store presented during reset still drives the interface combinationally.
        dm_ins_i     = {6'h2b, 26'h0};
        dm_alu_i     = 32'h10;
        dm_st_data_i = 32'h01020304;
        #1;
        chk("midrst.wen", 32'(Wen), 32'h1);
        chk("midrst.wdata", Wdata_d, 32'h01020304);
        @(negedge clk);
        rst = 1'b1;

        issue("postrst", 6'h24, 32'h03,    32'h0,        32'h00000080, 5'd7, 1, 10'h03,  0, 2'b00, 10'h0,   32'h0,        0,   0,   32'h00000080, 1);

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
